// File: rtl/alu_writeback_buffer_if.sv
// ALU-to-writeback bundle: ALU result input, register-file write port and operand-fetch
// forwarding lookup. in_bmd/ encoding: 0=BMD_08, 1=BMD_16, 2=BMD_32, 3=BMD_64.
interface alu_writeback_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_d;
    logic [63:0] in_eflags;
    logic        in_eflags_upd;
    logic        in_wr_en;
    logic [3:0]  in_dst;
    logic [1:0]  in_bmd;
    logic [63:0] eflags_as_src;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dst;
    logic [63:0] wb_old;
    logic [63:0] wb_data;
    logic [3:0]  fwd_idx;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic        fwd_stall;

    // Driven by the ALU / register file / operand-fetch side.
    modport master (
        output in_valid, in_d, in_eflags, in_eflags_upd, in_wr_en, in_dst, in_bmd,
        output wb_ready, wb_old, fwd_idx,
        input  in_ready, eflags_as_src, wb_valid, wb_dst, wb_data,
        input  fwd_hit, fwd_data, fwd_stall
    );

    modport slave (
        input  in_valid, in_d, in_eflags, in_eflags_upd, in_wr_en, in_dst, in_bmd,
        input  wb_ready, wb_old, fwd_idx,
        output in_ready, eflags_as_src, wb_valid, wb_dst, wb_data,
        output fwd_hit, fwd_data, fwd_stall
    );
endinterface

// File: rtl/alu_writeback_buffer.sv
// Post-ALU stage: architectural EFLAGS register, result FIFO to the register-file write port
// with x86-64 partial-width merge, and forwarding of buffered results to operand fetch.
module alu_writeback_buffer #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [63:0] EFLAGS_RST = 64'h2
) (
    input logic             clk,
    input logic             rst,
    alu_writeback_buffer_if.slave bus
);
    localparam logic [1:0] BMD_08 = 2'd0;
    localparam logic [1:0] BMD_16 = 2'd1;
    localparam logic [1:0] BMD_32 = 2'd2;
    localparam logic [1:0] BMD_64 = 2'd3;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]      d_mem   [DEPTH];
    logic [3:0]       dst_mem [DEPTH];
    logic [1:0]       bmd_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      eflags_q, eflags_d;

    logic acc, push, pop;

    assign bus.in_ready      = (count_q != CNT_W'(DEPTH));
    assign bus.wb_valid      = (count_q != '0);
    assign bus.eflags_as_src = eflags_q;

    assign acc  = bus.in_valid & bus.in_ready;
    assign push = acc & bus.in_wr_en;
    assign pop  = bus.wb_valid & bus.wb_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        eflags_d = (acc & bus.in_eflags_upd) ? bus.in_eflags : eflags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            eflags_q <= EFLAGS_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            eflags_q <= eflags_d;
        end
    end

    // Payload storage needs no reset: slots are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            d_mem[wr_ptr_q]   <= bus.in_d;
            dst_mem[wr_ptr_q] <= bus.in_dst;
            bmd_mem[wr_ptr_q] <= bus.in_bmd;
        end
    end

    logic [63:0] head_d;
    assign head_d     = d_mem[rd_ptr_q];
    assign bus.wb_dst = dst_mem[rd_ptr_q];

    // 8/16-bit writes preserve upper bits; 32-bit writes zero the upper half.
    always_comb begin
        bus.wb_data = head_d;
        unique case (bmd_mem[rd_ptr_q])
            BMD_08:  bus.wb_data = {bus.wb_old[63:8], head_d[7:0]};
            BMD_16:  bus.wb_data = {bus.wb_old[63:16], head_d[15:0]};
            BMD_32:  bus.wb_data = {32'b0, head_d[31:0]};
            BMD_64:  bus.wb_data = head_d;
            default: bus.wb_data = head_d;
        endcase
    end

    logic             fwd_found;
    logic [1:0]       fwd_bmd;
    logic [63:0]      fwd_d;
    logic [PTR_W-1:0] slot;

    // Walk oldest to newest so the newest matching entry overrides older ones.
    always_comb begin
        fwd_found = 1'b0;
        fwd_bmd   = BMD_64;
        fwd_d     = '0;
        slot      = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            slot = wr_ptr_q - PTR_W'(i) - PTR_W'(1);
            if (i < int'(count_q) && dst_mem[slot] == bus.fwd_idx) begin
                fwd_found = 1'b1;
                fwd_bmd   = bmd_mem[slot];
                fwd_d     = d_mem[slot];
            end
        end
    end

    always_comb begin
        bus.fwd_hit   = fwd_found & fwd_bmd[1];
        bus.fwd_stall = fwd_found & ~fwd_bmd[1];
        bus.fwd_data  = '0;
        if (bus.fwd_hit) begin
            bus.fwd_data = (fwd_bmd == BMD_32) ? {32'b0, fwd_d[31:0]} : fwd_d;
        end
    end
endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Scoreboard bench for alu_writeback_buffer: queue model of the FIFO, EFLAGS and a register file.
module tb_alu_writeback_buffer;
    localparam int unsigned DEPTH      = 2;
    localparam logic [63:0] EFLAGS_RST = 64'h2;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  dst;
        logic [1:0]  bmd;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_writeback_buffer_if bus ();

    alu_writeback_buffer #(
        .DEPTH      (DEPTH),
        .EFLAGS_RST (EFLAGS_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] rf [16];
    assign bus.wb_old = rf[bus.wb_dst];

    ent_t        q[$];
    logic [63:0] m_eflags = EFLAGS_RST;
    logic [63:0] last_wb;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input ent_t e);
        case (e.bmd)
            2'd0:    return {old[63:8], e.d[7:0]};
            2'd1:    return {old[63:16], e.d[15:0]};
            2'd2:    return {32'b0, e.d[31:0]};
            default: return e.d;
        endcase
    endfunction

    task automatic drive(input logic v, input logic wr, input logic [3:0] dst, input logic [1:0] bmd,
                         input logic [63:0] d, input logic [63:0] fl, input logic upd);
        bus.in_valid      = v;
        bus.in_wr_en      = wr;
        bus.in_dst        = dst;
        bus.in_bmd        = bmd;
        case (bmd)
            2'd0:    bus.in_d = {56'b0, d[7:0]};
            2'd1:    bus.in_d = {48'b0, d[15:0]};
            2'd2:    bus.in_d = {32'b0, d[31:0]};
            default: bus.in_d = d;
        endcase
        bus.in_eflags     = fl;
        bus.in_eflags_upd = upd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 2'd3, 64'd0, 64'd0, 1'b0);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic tick(output logic accepted);
        logic        pop_now, acc, found;
        ent_t        e, fe;
        logic [63:0] exp_wb;
        pop_now  = 1'b0;
        acc      = 1'b0;
        accepted = 1'b0;
        exp_wb   = '0;
        e        = '0;
        fe       = '0;
        @(negedge clk);
        if (!rst) begin
            check("in_ready", 64'(bus.in_ready), 64'(q.size() != DEPTH));
            check("wb_valid", 64'(bus.wb_valid), 64'(q.size() != 0));
            check("eflags", bus.eflags_as_src, m_eflags);
            found = 1'b0;
            foreach (q[i]) if (q[i].dst == bus.fwd_idx) begin found = 1'b1; fe = q[i]; end
            check("fwd_hit", 64'(bus.fwd_hit), 64'(found && fe.bmd[1]));
            check("fwd_stall", 64'(bus.fwd_stall), 64'(found && !fe.bmd[1]));
            check("fwd_data", bus.fwd_data, (found && fe.bmd[1]) ? fe.d : 64'd0);
            pop_now = bus.wb_ready && (q.size() != 0);
            if (pop_now) begin
                e      = q[0];
                exp_wb = merge(rf[e.dst], e);
                check("wb_dst", 64'(bus.wb_dst), 64'(e.dst));
                check("wb_data", bus.wb_data, exp_wb);
                last_wb = bus.wb_data;
            end
            acc = bus.in_valid && (q.size() != DEPTH);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_eflags = EFLAGS_RST;
        end else begin
            if (pop_now) begin
                void'(q.pop_front());
                rf[e.dst] = exp_wb;
            end
            if (acc && bus.in_wr_en) q.push_back('{d: bus.in_d, dst: bus.in_dst, bmd: bus.in_bmd});
            if (acc && bus.in_eflags_upd) m_eflags = bus.in_eflags;
            accepted = acc;
        end
    endtask

    task automatic ticks(input int n);
        logic a;
        repeat (n) tick(a);
    endtask

    initial begin
        logic        a;
        logic [63:0] fl;
        foreach (rf[i]) rf[i] = {$urandom, $urandom};
        idle();
        bus.wb_ready = 1'b0;
        bus.fwd_idx  = 4'd0;

        // T1: reset with two entries buffered.
        ticks(2);
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd1, 2'd3, 64'h1111, 64'h0, 1'b0);
        tick(a);
        drive(1'b1, 1'b1, 4'd2, 2'd3, 64'h2222, 64'h0, 1'b0);
        tick(a);
        idle();
        rst = 1'b1;
        tick(a);
        rst = 1'b0;
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_eflags", bus.eflags_as_src, 64'h2);
        check("rst_fwd", 64'({bus.fwd_hit, bus.fwd_stall}), 64'd0);

        // T2: flags-only op.
        drive(1'b1, 1'b0, 4'd0, 2'd3, 64'h0, 64'h46, 1'b1);
        tick(a);
        idle();
        check("t2_eflags", bus.eflags_as_src, 64'h46);
        check("t2_wb_valid", 64'(bus.wb_valid), 64'd0);
        ticks(1);

        // T3: partial-width merge.
        rf[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.wb_ready = 1'b1;
        drive(1'b1, 1'b1, 4'd3, 2'd0, 64'h12, 64'h0, 1'b0);
        tick(a);
        idle();
        tick(a);
        check("t3_merge8", last_wb, 64'hFFFF_FFFF_FFFF_FF12);
        drive(1'b1, 1'b1, 4'd3, 2'd2, 64'h1, 64'h0, 1'b0);
        tick(a);
        idle();
        tick(a);
        check("t3_merge32", last_wb, 64'h1);

        // T4: backpressure; third request held until the FIFO has room.
        bus.wb_ready = 1'b0;
        drive(1'b1, 1'b1, 4'd6, 2'd3, 64'hA1, 64'h81, 1'b1);
        tick(a);
        drive(1'b1, 1'b1, 4'd7, 2'd1, 64'hA2B2, 64'h82, 1'b1);
        tick(a);
        drive(1'b1, 1'b1, 4'd8, 2'd2, 64'hA3B3C3, 64'h83, 1'b1);
        ticks(3);
        check("t4_full", 64'(bus.in_ready), 64'd0);
        check("t4_eflags_held", bus.eflags_as_src, 64'h82);
        bus.wb_ready = 1'b1;
        a = 1'b0;
        for (int i = 0; i < 8 && !a; i++) tick(a);
        check("t4_third_accepted", 64'(a), 64'd1);
        idle();
        ticks(4);
        check("t4_drained", 64'(bus.wb_valid), 64'd0);

        // T5: forwarding, newest match wins; partial width stalls.
        bus.wb_ready = 1'b0;
        bus.fwd_idx  = 4'd5;
        drive(1'b1, 1'b1, 4'd5, 2'd3, 64'hAA, 64'h0, 1'b0);
        tick(a);
        drive(1'b1, 1'b1, 4'd5, 2'd3, 64'hBB, 64'h0, 1'b0);
        tick(a);
        idle();
        check("t5_hit", 64'({bus.fwd_hit, bus.fwd_stall}), 64'b10);
        check("t5_data", bus.fwd_data, 64'hBB);
        rst = 1'b1;
        tick(a);
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd5, 2'd3, 64'hAA, 64'h0, 1'b0);
        tick(a);
        drive(1'b1, 1'b1, 4'd5, 2'd1, 64'hBB, 64'h0, 1'b0);
        tick(a);
        idle();
        check("t5_stall", 64'({bus.fwd_hit, bus.fwd_stall}), 64'b01);
        check("t5_stall_data", bus.fwd_data, 64'h0);
        bus.wb_ready = 1'b1;
        tick(a);
        drive(1'b1, 1'b1, 4'd5, 2'd2, 64'hFFFF_FFFF_0000_00CC, 64'h0, 1'b0);
        tick(a);
        idle();
        ticks(3);

        // T6: steady push+pop at count 1, pointers wrapping.
        bus.fwd_idx = 4'd9;
        drive(1'b1, 1'b1, 4'd9, 2'd3, 64'h100, 64'h0, 1'b0);
        tick(a);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 4'(i), 2'(i), 64'h200 + 64'(i), 64'(i), 1'(i % 3 == 0));
            tick(a);
            check("t6_count1", 64'({bus.wb_valid, bus.in_ready}), 64'b11);
        end
        idle();
        ticks(3);

        // Random traffic with dense destination collisions.
        for (int i = 0; i < 300; i++) begin
            fl = {$urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), {$urandom, $urandom}, fl, 1'($urandom_range(0, 1)));
            bus.wb_ready = 1'($urandom_range(0, 1));
            bus.fwd_idx  = 4'($urandom_range(0, 3));
            tick(a);
        end
        idle();
        bus.wb_ready = 1'b1;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
